// File: rtl/fpu_share_arbiter_if.sv
// rtl/fpu_share_arbiter_if.sv - start/done handshake and operand bus between arbiter and shared FPU
interface fpu_share_arbiter_if #(
  parameter int OP_W = 3
);
  logic            fpu_start;
  logic [OP_W-1:0] fpu_op;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic            fpu_done;
  logic [31:0]     fpu_result;
  logic [4:0]      fpu_flags;

  modport master (
    output fpu_start, fpu_op, fpu_a, fpu_b,
    input  fpu_done, fpu_result, fpu_flags
  );

  modport slave (
    input  fpu_start, fpu_op, fpu_a, fpu_b,
    output fpu_done, fpu_result, fpu_flags
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin sharing of one multi-cycle FPU between two cores with watchdog
module fpu_share_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OP_W           = 3,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c0_req_valid,
  output logic             c0_req_ready,
  input  logic [OP_W-1:0]  c0_op,
  input  logic [31:0]      c0_a,
  input  logic [31:0]      c0_b,
  input  logic [TAG_W-1:0] c0_tag,
  input  logic             c1_req_valid,
  output logic             c1_req_ready,
  input  logic [OP_W-1:0]  c1_op,
  input  logic [31:0]      c1_a,
  input  logic [31:0]      c1_b,
  input  logic [TAG_W-1:0] c1_tag,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  fpu_share_arbiter_if.master fpu,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       wdog;
  logic             grant0;
  logic             grant1;

  // Ties go to the core that was not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      if (c0_req_valid && (!c1_req_valid || last_grant))
        grant0 = 1'b1;
      else if (c1_req_valid)
        grant1 = 1'b1;
    end
  end

  assign c0_req_ready = grant0;
  assign c1_req_ready = grant1;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      tag_q         <= '0;
      wdog          <= '0;
      fpu.fpu_start <= 1'b0;
      fpu.fpu_op    <= '0;
      fpu.fpu_a     <= '0;
      fpu.fpu_b     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      rsp_tag       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      fpu.fpu_start <= 1'b0;
      rsp_valid     <= '0;
      timeout_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            owner         <= grant1;
            fpu.fpu_op    <= grant1 ? c1_op  : c0_op;
            fpu.fpu_a     <= grant1 ? c1_a   : c0_a;
            fpu.fpu_b     <= grant1 ? c1_b   : c0_b;
            tag_q         <= grant1 ? c1_tag : c0_tag;
            fpu.fpu_start <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the final watchdog cycle still counts as a real result.
          if (fpu.fpu_done) begin
            rsp_result <= fpu.fpu_result;
            rsp_flags  <= fpu.fpu_flags;
            rsp_tag    <= tag_q;
            rsp_valid  <= owner ? 2'b10 : 2'b01;
            state      <= S_RESP;
          end else if (wdog == WDOG_LAST) begin
            rsp_result  <= 32'h7FC0_0000;
            rsp_flags   <= 5'b10000;
            rsp_tag     <= tag_q;
            rsp_valid   <= owner ? 2'b10 : 2'b01;
            timeout_err <= 1'b1;
            state       <= S_RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        S_RESP: begin
          last_grant <= owner;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - directed self-checking bench for fpu_share_arbiter
module tb_fpu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req_valid, c0_req_ready, c1_req_valid, c1_req_ready;
  logic [2:0]  c0_op, c1_op;
  logic [31:0] c0_a, c0_b, c1_a, c1_b;
  logic [4:0]  c0_tag, c1_tag;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags, rsp_tag;
  logic        busy, timeout_err;

  fpu_share_arbiter_if #(.OP_W(3)) ifc ();

  fpu_share_arbiter #(.TIMEOUT_CYCLES(64), .OP_W(3), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_op(c0_op),
    .c0_a(c0_a), .c0_b(c0_b), .c0_tag(c0_tag),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_op(c1_op),
    .c1_a(c1_a), .c1_b(c1_b), .c1_tag(c1_tag),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .fpu(ifc.master), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FPU model: done arrives after fpu_delay idle cycles following the start cycle; -1 = never.
  int          fpu_delay = 0;
  logic [31:0] fpu_res_val = 32'h0;
  logic [4:0]  fpu_flag_val = 5'h0;
  bit          armed = 1'b0;
  int          cnt = 0;
  bit          inject = 1'b0;

  initial begin
    ifc.fpu_done = 1'b0; ifc.fpu_result = '0; ifc.fpu_flags = '0;
    forever begin
      @(negedge clk);
      if (armed && cnt == 0) begin
        ifc.fpu_done = 1'b1; ifc.fpu_result = fpu_res_val; ifc.fpu_flags = fpu_flag_val; armed = 1'b0;
      end else begin
        ifc.fpu_done = inject;
        if (armed) cnt--;
      end
      inject = 1'b0;
      if (ifc.fpu_start && fpu_delay >= 0) begin armed = 1'b1; cnt = fpu_delay; end
    end
  end

  int onehot_viol = 0, start_viol = 0, to_pulses = 0, grants = 0, starts = 0;
  bit prev_hs = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (c0_req_ready && c1_req_ready) onehot_viol++;
      if (!rst && (ifc.fpu_start !== prev_hs)) start_viol++;
      if (timeout_err) to_pulses++;
      if (ifc.fpu_start) starts++;
      prev_hs = !rst && ((c0_req_valid && c0_req_ready) || (c1_req_valid && c1_req_ready));
      if (prev_hs) grants++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input int core, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit ok = 1'b0;
    if (core == 0) begin c0_op = op; c0_a = a; c0_b = b; c0_tag = tag; c0_req_valid = 1'b1; end
    else           begin c1_op = op; c1_a = a; c1_b = b; c1_tag = tag; c1_req_valid = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((core == 0) ? c0_req_ready : c1_req_ready) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_handshake: core %0d got no ready within 100 cycles", core); end
    tick();
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [1:0] v, output logic [31:0] r, output logic [4:0] f,
                          output logic [4:0] t, output logic to, output int n);
    v = '0; r = '0; f = '0; t = '0; to = 1'b0; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid != 2'b00) begin
        v = rsp_valid; r = rsp_result; f = rsp_flags; t = rsp_tag; to = timeout_err; break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    c0_op = '0; c0_a = '0; c0_b = '0; c0_tag = '0; c1_op = '0; c1_a = '0; c1_b = '0; c1_tag = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++;
    if ({rsp_result, rsp_flags, rsp_tag} !== 42'h0) begin
      errors++; $display("FAIL reset_rsp_fields: got %h/%h/%h expected 0/0/0", rsp_result, rsp_flags, rsp_tag);
    end
    checks++;
    if ({ifc.fpu_start, ifc.fpu_op, ifc.fpu_a, ifc.fpu_b} !== 68'h0) begin
      errors++; $display("FAIL reset_fpu_bus: got %b/%h/%h/%h expected all 0", ifc.fpu_start, ifc.fpu_op, ifc.fpu_a, ifc.fpu_b);
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++;
    if ({c0_req_ready, c1_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", c0_req_ready, c1_req_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] v; logic [31:0] r; logic [4:0] f, t; logic to; int n;
    fpu_delay = 3; fpu_res_val = 32'h4040_0000; fpu_flag_val = 5'b00000;
    tick();
    send(0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
    checks++;
    if ({ifc.fpu_start, ifc.fpu_a, ifc.fpu_b} !== {1'b1, 32'h3F80_0000, 32'h4000_0000}) begin
      errors++; $display("FAIL single_issue: got start=%b a=%h b=%h expected 1/3f800000/40000000", ifc.fpu_start, ifc.fpu_a, ifc.fpu_b);
    end
    wait_rsp(v, r, f, t, to, n);
    checks++; if (v !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", v); end
    checks++; if (r !== 32'h4040_0000) begin errors++; $display("FAIL single_result: got %h expected 40400000", r); end
    checks++; if (t !== 5'd5) begin errors++; $display("FAIL single_tag: got %0d expected 5", t); end
    checks++; if (n != 6) begin errors++; $display("FAIL single_latency: got %0d expected 6", n); end
  endtask

  int         g[8];
  logic [1:0] rv[8];
  logic [4:0] rt[8];

  task automatic run_both(input int nops, input bit hold, output int ng, output int nr);
    bit d0, d1;
    ng = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin g[i] = -1; rv[i] = '0; rt[i] = '0; end
    c0_op = 3'd1; c0_a = 32'h1; c0_b = 32'h2; c0_tag = 5'd1;
    c1_op = 3'd2; c1_a = 32'h3; c1_b = 32'h4; c1_tag = 5'd2;
    c0_req_valid = 1'b1; c1_req_valid = 1'b1;
    for (int i = 0; i < 400 && nr < nops; i++) begin
      @(negedge clk);
      d0 = 1'b0; d1 = 1'b0;
      if (c0_req_ready) begin if (ng < 8) g[ng] = 0; ng++; d0 = !hold; end
      if (c1_req_ready) begin if (ng < 8) g[ng] = 1; ng++; d1 = !hold; end
      if (rsp_valid != 2'b00) begin
        if (nr < 8) begin rv[nr] = rsp_valid; rt[nr] = rsp_tag; end
        nr++;
      end
      tick();
      if (d0) c0_req_valid = 1'b0;
      if (d1) c1_req_valid = 1'b0;
    end
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
  endtask

  task automatic test_tie();
    int ng, nr;
    apply_reset();
    fpu_delay = 1; fpu_res_val = 32'h0000_00AA;
    run_both(2, 1'b0, ng, nr);
    checks++; if (ng != 2 || nr != 2) begin errors++; $display("FAIL tie_counts: got grants=%0d rsps=%0d expected 2/2", ng, nr); end
    checks++; if (g[0] != 0 || g[1] != 1) begin errors++; $display("FAIL tie_grant_order: got %0d,%0d expected 0,1", g[0], g[1]); end
    checks++; if (rv[0] !== 2'b01 || rv[1] !== 2'b10) begin errors++; $display("FAIL tie_rsp_order: got %b,%b expected 01,10", rv[0], rv[1]); end
    checks++; if (rt[0] !== 5'd1 || rt[1] !== 5'd2) begin errors++; $display("FAIL tie_rsp_tag: got %0d,%0d expected 1,2", rt[0], rt[1]); end
  endtask

  task automatic test_starvation();
    int ng, nr;
    fpu_delay = 0;
    run_both(8, 1'b1, ng, nr);
    checks++; if (ng != 8 || nr != 8) begin errors++; $display("FAIL starve_counts: got grants=%0d rsps=%0d expected 8/8", ng, nr); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g[i] != (i % 2)) begin errors++; $display("FAIL starve_grant_%0d: got %0d expected %0d", i, g[i], i % 2); end
    end
    checks++; if (rv[7] !== 2'b10) begin errors++; $display("FAIL starve_last_rsp: got %b expected 10", rv[7]); end
  endtask

  task automatic test_watchdog();
    logic [1:0] v; logic [31:0] r; logic [4:0] f, t; logic to; int n, p0;
    fpu_delay = -1;
    tick();
    p0 = to_pulses;
    send(1, 3'd3, 32'h4120_0000, 32'h0, 5'd9);
    wait_rsp(v, r, f, t, to, n);
    checks++; if (v !== 2'b10) begin errors++; $display("FAIL wdog_rsp_valid: got %b expected 10", v); end
    checks++; if (r !== 32'h7FC0_0000) begin errors++; $display("FAIL wdog_result: got %h expected 7fc00000", r); end
    checks++; if (f !== 5'b10000) begin errors++; $display("FAIL wdog_flags: got %b expected 10000", f); end
    checks++; if (t !== 5'd9) begin errors++; $display("FAIL wdog_tag: got %0d expected 9", t); end
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL wdog_timeout_err: got %b expected 1", to); end
    checks++; if (n != 66) begin errors++; $display("FAIL wdog_latency: got %0d expected 66", n); end
    tick();
    checks++; if (to_pulses - p0 != 1) begin errors++; $display("FAIL wdog_pulse_count: got %0d expected 1", to_pulses - p0); end

    fpu_delay = 63; fpu_res_val = 32'h1234_5678; fpu_flag_val = 5'b00001;
    p0 = to_pulses;
    send(0, 3'd2, 32'h3F80_0000, 32'h3F80_0000, 5'd3);
    wait_rsp(v, r, f, t, to, n);
    checks++; if (v !== 2'b01) begin errors++; $display("FAIL race_rsp_valid: got %b expected 01", v); end
    checks++; if (r !== 32'h1234_5678 || f !== 5'b00001) begin errors++; $display("FAIL race_result: got %h/%b expected 12345678/00001", r, f); end
    checks++; if (n != 66) begin errors++; $display("FAIL race_latency: got %0d expected 66", n); end
    tick();
    checks++; if (to_pulses != p0) begin errors++; $display("FAIL race_no_timeout: got %0d pulses expected 0", to_pulses - p0); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] v; logic [31:0] r; logic [4:0] f, t; logic to; int n, bad;
    fpu_delay = 10; fpu_res_val = 32'hDEAD_BEEF;
    tick();
    send(0, 3'd1, 32'h4000_0000, 32'h4000_0000, 5'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || ifc.fpu_a !== 32'h0) begin
      errors++; $display("FAIL rstmid_abort: got busy=%b rsp=%b a=%h expected 0/00/0", busy, rsp_valid, ifc.fpu_a);
    end
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy || ifc.fpu_start) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
    fpu_delay = 0; fpu_res_val = 32'h3F80_0000;
    tick();
    send(1, 3'd0, 32'h3F00_0000, 32'h3F00_0000, 5'd11);
    wait_rsp(v, r, f, t, to, n);
    checks++;
    if (v !== 2'b10 || r !== 32'h3F80_0000 || t !== 5'd11) begin
      errors++; $display("FAIL rstmid_next: got %b/%h/%0d expected 10/3f800000/11", v, r, t);
    end
    checks++; if (n != 3) begin errors++; $display("FAIL rstmid_next_latency: got %0d expected 3", n); end
  endtask

  task automatic test_protocol();
    int bad;
    tick();
    inject = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || rsp_valid != 2'b00 || ifc.fpu_start || timeout_err) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stray_done: got %0d reacting cycles expected 0", bad); end
    checks++; if (onehot_viol != 0) begin errors++; $display("FAIL ready_onehot: got %0d violations expected 0", onehot_viol); end
    checks++; if (start_viol != 0) begin errors++; $display("FAIL start_per_grant: got %0d violations expected 0", start_viol); end
    checks++; if (grants != 15) begin errors++; $display("FAIL grant_total: got %0d expected 15", grants); end
    checks++; if (starts != 15) begin errors++; $display("FAIL start_total: got %0d expected 15", starts); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_starvation();
    test_watchdog();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
